// File: rtl/ece298a_pkg.sv
// Shared definitions for the ece298a control block and datapath.
// Control-word bit positions, opcode encodings and default widths.
package ece298a_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int ADDR_W_DEFAULT = 4;
  localparam int CTRL_W         = 16;

  localparam int CTRL_HLT = 15;
  localparam int CTRL_MI  = 14;
  localparam int CTRL_RI  = 13;
  localparam int CTRL_RO  = 12;
  localparam int CTRL_IO  = 11;
  localparam int CTRL_II  = 10;
  localparam int CTRL_AI  = 9;
  localparam int CTRL_AO  = 8;
  localparam int CTRL_EO  = 7;
  localparam int CTRL_SU  = 6;
  localparam int CTRL_BI  = 5;
  localparam int CTRL_OI  = 4;
  localparam int CTRL_CE  = 3;
  localparam int CTRL_CO  = 2;
  localparam int CTRL_J   = 1;
  localparam int CTRL_FI  = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

endpackage

// File: rtl/ece298a_alu.sv
// Combinational adder/subtractor for the ece298a datapath.
// Subtraction is A + ~B + 1, so carry=1 means no borrow.
module ece298a_alu
  import ece298a_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  always_comb begin
    b_op = sub ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub};
  end

  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];

endmodule

// File: rtl/ece298a_datapath.sv
// SAP-style datapath: PC, MAR, RAM, IR, A/B, ALU, flags, OUT and shared bus.
// Executes one control word per cycle issued by the ece298a control block.
module ece298a_datapath
  import ece298a_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_word,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic [DATA_W-1:0] out_val,
  output logic [ADDR_W-1:0] pc_val,
  output logic [DATA_W-1:0] bus_val,
  output logic              halted,
  output logic              bus_err
);

  logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, jmp, fi;

  assign hlt = ctrl_word[CTRL_HLT];
  assign mi  = ctrl_word[CTRL_MI];
  assign ri  = ctrl_word[CTRL_RI];
  assign ro  = ctrl_word[CTRL_RO];
  assign io  = ctrl_word[CTRL_IO];
  assign ii  = ctrl_word[CTRL_II];
  assign ai  = ctrl_word[CTRL_AI];
  assign ao  = ctrl_word[CTRL_AO];
  assign eo  = ctrl_word[CTRL_EO];
  assign su  = ctrl_word[CTRL_SU];
  assign bi  = ctrl_word[CTRL_BI];
  assign oi  = ctrl_word[CTRL_OI];
  assign ce  = ctrl_word[CTRL_CE];
  assign co  = ctrl_word[CTRL_CO];
  assign jmp = ctrl_word[CTRL_J];
  assign fi  = ctrl_word[CTRL_FI];

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic              cf;
  logic              zf;
  logic              halted_q;
  logic              bus_err_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W-1:0] bus;
  logic [4:0]        drv;
  logic              multi_drv;

  ece298a_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .sub    (su),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // A set with more than one bit has a nonzero AND with itself minus one.
  assign drv       = {co, ro, io, ao, eo};
  assign multi_drv = |(drv & (drv - 5'd1));

  always_comb begin
    bus = '0;
    if (co) bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
    if (ro) bus = mem[mar];
    if (io) bus = {{(DATA_W-4){1'b0}}, ir[3:0]};
    if (ao) bus = a_reg;
    if (eo) bus = alu_res;
    if (multi_drv) bus = '0;
  end

  // Program load owns the write port whenever it is active, even under reset or halt.
  always_ff @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    else if (!rst && !halted_q && ri)
      mem[mar] <= bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (multi_drv) bus_err_q <= 1'b1;
      if (!halted_q) begin
        if (hlt) halted_q <= 1'b1;
        if (mi)  mar      <= bus[ADDR_W-1:0];
        if (ii)  ir       <= bus;
        if (ai)  a_reg    <= bus;
        if (bi)  b_reg    <= bus;
        if (oi)  out_reg  <= bus;
        if (fi) begin
          cf <= alu_carry;
          zf <= (alu_res == '0);
        end
        if (jmp)     pc <= bus[ADDR_W-1:0];
        else if (ce) pc <= pc + ADDR_W'(1);
      end
    end
  end

  assign opcode     = ir[7:4];
  assign carry_flag = cf;
  assign zero_flag  = zf;
  assign out_val    = out_reg;
  assign pc_val     = pc;
  assign bus_val    = bus;
  assign halted     = halted_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ece298a_datapath.sv
// Directed testbench for ece298a_datapath with hand-computed expectations.
module tb_ece298a_datapath;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ctrl_word;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic [7:0]  out_val;
  logic [3:0]  pc_val;
  logic [7:0]  bus_val;
  logic        halted;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  ece298a_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_word  (ctrl_word),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .out_val    (out_val),
    .pc_val     (pc_val),
    .bus_val    (bus_val),
    .halted     (halted),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [15:0] cw);
    ctrl_word = cw;
    @(posedge clk);
    #1;
    ctrl_word = '0;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ctrl_word = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    ctrl_word = '0;
    n_tests++; if (pc_val !== 4'h0)     begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_val); end
    n_tests++; if (out_val !== 8'h00)   begin n_fail++; $display("FAIL reset_out got %h want 00", out_val); end
    n_tests++; if (opcode !== 4'h0)     begin n_fail++; $display("FAIL reset_opcode got %h want 0", opcode); end
    n_tests++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", carry_flag, zero_flag); end
    n_tests++; if (halted !== 1'b0)     begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_tests++; if (bus_err !== 1'b0)    begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
  endtask

  task automatic test_fetch;
    // Program is streamed while reset is held.
    load(4'd0, 8'h1E);
    load(4'd1, 8'h1F);
    load(4'd14, 8'h1C);
    load(4'd15, 8'h0E);
    rst = 1'b0;
    ctrl_word = '0; #1;
    n_tests++; if (bus_val !== 8'h00) begin n_fail++; $display("FAIL idle_bus got %h want 00", bus_val); end
    step(CO | MI);
    step(RO | II | CE);
    n_tests++; if (opcode !== 4'h1) begin n_fail++; $display("FAIL fetch_opcode got %h want 1", opcode); end
    n_tests++; if (pc_val !== 4'h1) begin n_fail++; $display("FAIL fetch_pc got %h want 1", pc_val); end
    step(IO | MI);
    step(RO | AI);
    ctrl_word = AO; #1;
    n_tests++; if (bus_val !== 8'h1C) begin n_fail++; $display("FAIL lda_a got %h want 1C", bus_val); end
    ctrl_word = '0;
    step(CO | MI);
    step(RO | II);
    ctrl_word = IO; #1;
    n_tests++; if (bus_val !== 8'h0F) begin n_fail++; $display("FAIL io_drive got %h want 0F", bus_val); end
    step(IO | MI);
    step(RO | BI);
    step(EO | AI | FI);
    ctrl_word = AO; #1;
    n_tests++; if (bus_val !== 8'h2A) begin n_fail++; $display("FAIL add_a got %h want 2A", bus_val); end
    ctrl_word = '0;
    n_tests++; if (opcode !== 4'h1 || pc_val !== 4'h1) begin n_fail++; $display("FAIL add_op_pc got %h/%h want 1/1", opcode, pc_val); end
    n_tests++; if ({carry_flag, zero_flag} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b%b want 00", carry_flag, zero_flag); end
  endtask

  task automatic test_sub_equal;
    // MAR stays at 15; RAM[15] is rewritten to feed A and B.
    load(4'd15, 8'h05);
    step(RO | AI);
    step(RO | BI);
    step(SU | EO | OI | FI);
    n_tests++; if (out_val !== 8'h00) begin n_fail++; $display("FAIL sub_out got %h want 00", out_val); end
    n_tests++; if (zero_flag !== 1'b1) begin n_fail++; $display("FAIL sub_zf got %b want 1", zero_flag); end
    n_tests++; if (carry_flag !== 1'b1) begin n_fail++; $display("FAIL sub_cf got %b want 1", carry_flag); end
  endtask

  task automatic test_add_overflow;
    load(4'd15, 8'hF0);
    step(RO | AI);
    load(4'd15, 8'h20);
    step(RO | BI);
    step(EO | AI | FI);
    ctrl_word = AO; #1;
    n_tests++; if (bus_val !== 8'h10) begin n_fail++; $display("FAIL ovf_a got %h want 10", bus_val); end
    ctrl_word = '0;
    n_tests++; if ({carry_flag, zero_flag} !== 2'b10) begin n_fail++; $display("FAIL ovf_flags got %b%b want 10", carry_flag, zero_flag); end
    step(SU | EO | OI);
    n_tests++; if (out_val !== 8'hF0) begin n_fail++; $display("FAIL sub_nofi_out got %h want F0", out_val); end
    n_tests++; if ({carry_flag, zero_flag} !== 2'b10) begin n_fail++; $display("FAIL flags_hold got %b%b want 10", carry_flag, zero_flag); end
  endtask

  task automatic test_ram_write;
    load(4'd15, 8'h99);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h77;
    step(AO | RI);
    prog_we = 1'b0;
    ctrl_word = RO; #1;
    n_tests++; if (bus_val !== 8'h99) begin n_fail++; $display("FAIL ri_dropped got %h want 99", bus_val); end
    ctrl_word = '0;
    step(AO | RI);
    ctrl_word = RO; #1;
    n_tests++; if (bus_val !== 8'h10) begin n_fail++; $display("FAIL ri_write got %h want 10", bus_val); end
    ctrl_word = '0;
  endtask

  task automatic test_pc_wrap_jump;
    rst = 1'b1;
    load(4'd0, 8'h07);
    rst = 1'b0;
    step(RO | II);
    for (int i = 0; i < 15; i++) step(CE);
    n_tests++; if (pc_val !== 4'hF) begin n_fail++; $display("FAIL pc_15 got %h want F", pc_val); end
    step(CE);
    n_tests++; if (pc_val !== 4'h0) begin n_fail++; $display("FAIL pc_wrap got %h want 0", pc_val); end
    step(IO | J | CE);
    n_tests++; if (pc_val !== 4'h7) begin n_fail++; $display("FAIL jump_wins got %h want 7", pc_val); end
  endtask

  task automatic test_conflict_halt;
    step(RO | AI);
    step(RO | BI);
    ctrl_word = AO | CO; #1;
    n_tests++; if (bus_val !== 8'h00) begin n_fail++; $display("FAIL conflict_bus got %h want 00", bus_val); end
    step(AO | CO);
    for (int i = 0; i < 5; i++) step('0);
    n_tests++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL bus_err_sticky got %b want 1", bus_err); end
    step(HLT);
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halted got %b want 1", halted); end
    step(EO | AI | CE | OI);
    ctrl_word = AO; #1;
    n_tests++; if (bus_val !== 8'h07) begin n_fail++; $display("FAIL halt_a got %h want 07", bus_val); end
    ctrl_word = '0;
    n_tests++; if (pc_val !== 4'h7 || out_val !== 8'h00) begin n_fail++; $display("FAIL halt_pc_out got %h/%h want 7/00", pc_val, out_val); end
    load(4'd3, 8'h55);
    rst = 1'b1;
    load(4'd0, 8'h03);
    rst = 1'b0;
    n_tests++; if (halted !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_clears got %b/%b want 0/0", halted, bus_err); end
    step(RO | II);
    step(IO | MI);
    ctrl_word = RO; #1;
    n_tests++; if (bus_val !== 8'h55) begin n_fail++; $display("FAIL halted_load got %h want 55", bus_val); end
    ctrl_word = '0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl_word = '0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    test_reset;
    test_fetch;
    test_sub_equal;
    test_add_overflow;
    test_ram_write;
    test_pc_wrap_jump;
    test_conflict_halt;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ece298a_datapath.md
Name: ece298a_datapath

Overview:
- SAP-style 8-bit datapath that sits directly downstream of the ece298a control block and executes the control word it issues each cycle.
- Contains the program counter, MAR, 16x8 RAM, instruction register, A/B registers, the ALU, flags, the output register and a shared internal bus.
- Returns the opcode and flags to the control block.

Parameters:
- DATA_W, 8, bus/register/RAM word width.
- ADDR_W, 4, PC/MAR width; RAM depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- ctrl_word  in  16  control bits, index order (MSB..LSB): HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI.
- prog_we  in  1  external RAM program-load write strobe.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- opcode  out  4  IR[7:4], to the control block.
- carry_flag  out  1  registered carry.
- zero_flag  out  1  registered zero.
- out_val  out  DATA_W  output register.
- pc_val  out  ADDR_W  current PC.
- bus_val  out  DATA_W  combinational bus value, for debug.
- halted  out  1  sticky halt.
- bus_err  out  1  sticky multi-driver error.

Behaviour:
- Reset (rst=1 at a clk edge): PC, MAR, IR, A, B, OUT, CF, ZF, halted and bus_err all go to 0. RAM is not cleared.
- Bus (combinational) drivers:
  - CO drives {0,PC}.
  - RO drives RAM[MAR] (asynchronous read).
  - IO drives {0,IR[3:0]}.
  - AO drives A.
  - EO drives ALU[7:0].
- Bus rules:
  - No driver: bus=0.
  - More than one driver: bus=0, and bus_err is set on the next edge and holds until rst.
- ALU (combinational, 9-bit result):
  - SU=0: A+B.
  - SU=1: A+~B+1.
  - carry = bit 8. For subtraction, carry=1 means no borrow (A>=B).
- Register loads, at the rising edge, only when halted=0 and rst=0:
  - MI: MAR<=bus[ADDR_W-1:0].
  - RI: RAM[MAR]<=bus, using the pre-edge MAR even if MI is asserted in the same cycle.
  - II: IR<=bus.
  - AI: A<=bus.
  - BI: B<=bus.
  - OI: OUT<=bus.
  - FI: CF<=carry, ZF<=(ALU[7:0]==0). Flags are unchanged otherwise.
- PC update:
  - CE: PC<=PC+1, wrapping 15->0.
  - J: PC<=bus[ADDR_W-1:0].
  - J and CE together: J wins.
- Same-cycle read/write: a register both driving and loading the bus (e.g. EO|AI) samples the pre-edge combinational value. No latency beyond one edge.
- HLT: halted<=1 at the edge. From the following edge on, all loads, PC and flag updates are suppressed; bus_err detection stays active. Only rst clears halted.
- prog_we:
  - Writes RAM[prog_addr]<=prog_data at any edge, including while rst=1 and while halted. This is the required program-load method: hold rst and stream the program.
  - prog_we and RI in the same cycle: prog_we wins, and the RI write is dropped even if the addresses differ.
- Reset mid-instruction: every register except RAM returns to reset values at that edge. The control block is responsible for restarting its T-state.

Decomposition:
- Package ece298a_pkg holds:
  - localparam bit indices CTRL_HLT..CTRL_FI, plus CTRL_W=16.
  - the opcode enum (NOP, LDA, ADD, SUB, STA, LDI, JMP, JC, JZ, OUT, HLT).
  - DATA_W/ADDR_W defaults.
  - The control block shares this package.
- One sub-module, ece298a_alu: purely combinational. Inputs a, b, sub; outputs result[DATA_W-1:0] and carry.
- Bus mux, conflict detect, registers and RAM stay in the top module.

Test Plan:
- Reset: apply garbage ctrl_word with rst=1 for 2 cycles -> pc_val=0, out_val=0, opcode=0, flags=0, halted=0, bus_err=0.
- Program load and fetch:
  - Stimulus: with rst=1, prog_we writes RAM[0]=0x1E, RAM[14]=0x1C, RAM[15]=0x0E; release rst; run CO|MI, RO|II|CE, IO|MI, RO|AI, then MI with IO driving 0x0F, RO|BI, EO|AI|FI.
  - Response: opcode=1, pc_val=1, A=0x2A, CF=0, ZF=0.
- Subtract equal: A=0x05, B=0x05, then SU|EO|OI|FI -> out_val=0x00, zero_flag=1, carry_flag=1.
- Add overflow: A=0xF0, B=0x20, then EO|AI|FI -> A=0x10, carry_flag=1, zero_flag=0.
- PC wrap and jump:
  - 16 CE cycles from 0 -> pc_val=0.
  - Then IO with IR[3:0]=7 and J|CE -> pc_val=7, not 8.
- Conflict and halt:
  - AO|CO -> bus_val=0, bus_err=1, which persists through 5 idle cycles.
  - HLT, then IO|AI -> A unchanged, halted=1.
  - prog_we RAM[3]=0x55 while halted, then rst, then MI with IO=3 and RO -> bus_val=0x55.
